muldiv_unit: RTL

- Iterative multiply/divide unit for the MIPS execute stage; generalises the combinational funct decoder into a parametrised, multi-cycle functional unit.
- Decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO from funct and owns the architectural HI/LO registers.
- Exposes busy so hazard logic stalls MFHI/MFLO and any new MDU op until the result lands.

---
 rtl/muldiv_pkg.sv | 11 +
 rtl/muldiv_sign_fix.sv | 10 +
 rtl/muldiv_unit.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared funct codes, FSM states and op kinds for the multiply/divide unit
package muldiv_pkg;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
  typedef enum logic [1:0] {IDLE, CALC, FIX} muldiv_state_t;
  typedef enum logic {OP_MUL, OP_DIV} muldiv_op_t;
endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: conditional two's-complement negate, used for operand magnitudes and result signs
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);
  assign res = neg ? -val : val;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS MULT/MULTU/DIV/DIVU unit owning HI/LO.
// MULDIV_FAST_MUL_EN swaps the shift-add multiply for a single-cycle combinational multiplier.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);
  muldiv_state_t      state_q, state_d;
  muldiv_op_t         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic               qneg_q, qneg_d, rneg_q, rneg_d, dzp_q, dzp_d;
  logic               done_q, done_d, dz_q, dz_d, busy_q, busy_d;
  logic               is_mul, is_div, is_sgn;
  logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix, diff;
  logic [2*WIDTH-1:0] prod_fix, mul_step, div_step;
  logic [WIDTH:0]     sum, top;
  logic               ge;

  assign is_mul = funct == FUNCT_MULT || funct == FUNCT_MULTU;
  assign is_div = funct == FUNCT_DIV || funct == FUNCT_DIVU;
  assign is_sgn = funct == FUNCT_MULT || funct == FUNCT_DIV;

  muldiv_sign_fix #(.W(WIDTH))   u_mag_a (.val(op_a), .neg(is_sgn & op_a[WIDTH-1]), .res(a_mag));
  muldiv_sign_fix #(.W(WIDTH))   u_mag_b (.val(op_b), .neg(is_sgn & op_b[WIDTH-1]), .res(b_mag));
  muldiv_sign_fix #(.W(2*WIDTH)) u_fix_p (.val(acc_q), .neg(qneg_q), .res(prod_fix));
  muldiv_sign_fix #(.W(WIDTH))   u_fix_q (.val(acc_q[WIDTH-1:0]), .neg(qneg_q), .res(quo_fix));
  muldiv_sign_fix #(.W(WIDTH))   u_fix_r (.val(acc_q[2*WIDTH-1:WIDTH]), .neg(rneg_q), .res(rem_fix));

  // acc holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    mul_step = {sum, acc_q[WIDTH-1:1]};
    top      = acc_q[2*WIDTH-1:WIDTH-1];
    ge       = top >= {1'b0, m_q};
    diff     = top[WIDTH-1:0] - m_q;
    div_step = {ge ? diff : top[WIDTH-1:0], acc_q[WIDTH-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    m_d     = m_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dzp_d   = dzp_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    if (flush)
      state_d = IDLE;
    else
      case (state_q)
        IDLE:
          if (start && (is_mul || is_div)) begin
            op_d    = is_div ? OP_DIV : OP_MUL;
            m_d     = is_div ? b_mag : a_mag;
            acc_d   = {{WIDTH{1'b0}}, is_div ? a_mag : b_mag};
            qneg_d  = is_sgn & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            rneg_d  = is_sgn & op_a[WIDTH-1];
            cnt_d   = CNT_W'(WIDTH - 1);
            dz_d    = 1'b0;
            dzp_d   = 1'b0;
            state_d = CALC;
            if (is_div && op_b == '0) begin
              acc_d   = {op_a, {WIDTH{1'b1}}};
              qneg_d  = 1'b0;
              rneg_d  = 1'b0;
              dzp_d   = 1'b1;
              state_d = FIX;
            end
`ifdef MULDIV_FAST_MUL_EN
            if (is_mul) begin
              acc_d   = (2*WIDTH)'(a_mag) * (2*WIDTH)'(b_mag);
              state_d = FIX;
            end
`endif
          end else if (start && funct == FUNCT_MTHI)
            hi_d = op_a;
          else if (start && funct == FUNCT_MTLO)
            lo_d = op_a;
        CALC: begin
          acc_d   = op_q == OP_MUL ? mul_step : div_step;
          cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - CNT_W'(1);
          state_d = cnt_q == '0 ? FIX : CALC;
        end
        FIX: begin
          {hi_d, lo_d} = op_q == OP_MUL ? prod_fix : {rem_fix, quo_fix};
          dz_d    = dzp_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dzp_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dzp_q   <= dzp_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;
endmodule
